// File: rtl/camera_pkg.sv
// Shared definitions for the camera byte-stream generator: state encoding,
// default frame geometry and a width helper for counters.
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK
  } cam_state_t;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_BLANK      = 144;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_SYNC_LINES = 3;
  localparam int DEF_V_BACK_LINES = 17;

  // Counter width that holds values 0..count-1, never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/camera_stream_gen.sv
// Camera-style parallel video source: turns a handshaked RGB565 pixel stream
// into vsync/href framing with one byte per clock, high byte first.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no frame running, vsync high, waiting for enable
// ST_VSYNC  | vertical sync, vsync high for V_SYNC_LINES line periods
// ST_VBACK  | vertical back porch, vsync low, href low
// ST_ACTIVE | href high, two bytes per pixel for 2*H_ACTIVE cycles
// ST_HBLANK | href low for H_BLANK cycles between/after active lines
module camera_stream_gen
  import camera_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_BLANK      = DEF_H_BLANK,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_LINES = DEF_V_SYNC_LINES,
  parameter int V_BACK_LINES = DEF_V_BACK_LINES
) (
  input  logic        p_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pixel_in,
  input  logic        pixel_in_valid,
  output logic        pixel_in_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_start,
  output logic        underrun
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int LINES_MAX = (V_ACTIVE > V_SYNC_LINES)
                             ? ((V_ACTIVE > V_BACK_LINES) ? V_ACTIVE : V_BACK_LINES)
                             : ((V_SYNC_LINES > V_BACK_LINES) ? V_SYNC_LINES : V_BACK_LINES);
  localparam int CW = cnt_width(LINE_LEN);
  localparam int LW = cnt_width(LINES_MAX);

  localparam logic [CW-1:0] COL_LAST     = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] COL_ACT_LAST = CW'(2 * H_ACTIVE - 1);
  localparam logic [LW-1:0] SYNC_LAST    = LW'(V_SYNC_LINES - 1);
  localparam logic [LW-1:0] BACK_LAST    = LW'(V_BACK_LINES - 1);
  localparam logic [LW-1:0] ACT_LAST     = LW'(V_ACTIVE - 1);

  cam_state_t    state;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic          phase;
  logic [7:0]    low_byte;
  logic          col_end;

  assign col_end = (col == COL_LAST);

  // Request a pixel in the cycle just before each high byte goes out.
  always_comb begin
    pixel_in_ready = 1'b0;
    case (state)
      ST_VBACK:  pixel_in_ready = col_end && (line == BACK_LAST);
      ST_ACTIVE: pixel_in_ready = phase && (col != COL_ACT_LAST);
      ST_HBLANK: pixel_in_ready = col_end && (line != ACT_LAST);
      default:   pixel_in_ready = 1'b0;
    endcase
  end

  // Frame sequencing, counters and registered outputs.
  always_ff @(posedge p_clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      line        <= '0;
      phase       <= 1'b0;
      low_byte    <= 8'h00;
      vsync       <= 1'b1;
      href        <= 1'b0;
      p_data      <= 8'h00;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      // Byte path: high byte on the cycle after a request, low byte after
      // that; a starved request still occupies its slot with zeros.
      if (pixel_in_ready) begin
        if (pixel_in_valid) begin
          p_data   <= pixel_in[15:8];
          low_byte <= pixel_in[7:0];
        end else begin
          p_data   <= 8'h00;
          low_byte <= 8'h00;
          underrun <= 1'b1;
        end
      end else if (state == ST_ACTIVE && !phase) begin
        p_data <= low_byte;
      end else begin
        p_data <= 8'h00;
      end

      col <= col_end ? '0 : col + 1'b1;

      case (state)
        ST_IDLE: begin
          col   <= '0;
          line  <= '0;
          phase <= 1'b0;
          if (enable) state <= ST_VSYNC;
        end
        ST_VSYNC: begin
          if (col_end) begin
            if (line == SYNC_LAST) begin
              line        <= '0;
              state       <= ST_VBACK;
              vsync       <= 1'b0;
              frame_start <= 1'b1;
            end else begin
              line <= line + 1'b1;
            end
          end
        end
        ST_VBACK: begin
          if (col_end) begin
            if (line == BACK_LAST) begin
              line  <= '0;
              state <= ST_ACTIVE;
              href  <= 1'b1;
              phase <= 1'b0;
            end else begin
              line <= line + 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          phase <= ~phase;
          if (col == COL_ACT_LAST) begin
            state <= ST_HBLANK;
            href  <= 1'b0;
            phase <= 1'b0;
          end
        end
        ST_HBLANK: begin
          if (col_end) begin
            if (line == ACT_LAST) begin
              line  <= '0;
              vsync <= 1'b1;
              state <= enable ? ST_VSYNC : ST_IDLE;
            end else begin
              line  <= line + 1'b1;
              state <= ST_ACTIVE;
              href  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_stream_gen.sv
// Bench for camera_stream_gen with a small frame geometry. A source process
// feeds pixels and records each consumed slot into a scoreboard; a monitor
// tracks frame position arithmetically and checks framing and bytes.
module tb_camera_stream_gen;

  localparam int H_ACTIVE     = 4;
  localparam int H_BLANK      = 2;
  localparam int V_ACTIVE     = 3;
  localparam int V_SYNC_LINES = 1;
  localparam int V_BACK_LINES = 1;
  localparam int LINE_LEN     = 2 * H_ACTIVE + H_BLANK;
  localparam int VB_CYC       = V_BACK_LINES * LINE_LEN;
  localparam int FRAME_LOW    = VB_CYC + V_ACTIVE * LINE_LEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pixel_in = 16'h0000;
  logic        pixel_in_valid = 1'b0;
  logic        pixel_in_ready;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_start;
  logic        underrun;

  camera_stream_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .V_SYNC_LINES(V_SYNC_LINES),
    .V_BACK_LINES(V_BACK_LINES)
  ) dut (
    .p_clock       (clk),
    .reset         (reset),
    .enable        (enable),
    .pixel_in      (pixel_in),
    .pixel_in_valid(pixel_in_valid),
    .pixel_in_ready(pixel_in_ready),
    .vsync         (vsync),
    .href          (href),
    .p_data        (p_data),
    .frame_start   (frame_start),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       ur;
  } pair_t;

  pair_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mode = 0;        // 0 always valid, 1 starve third slot, 2 random
  logic [15:0] next_pix = 16'h1234;
  int          slot_cnt = 0;
  int          slot_base = 0;
  int          fpos = -1;
  int          vs_run = 0;
  bit          cont = 1'b0;
  int          frames_done = 0;
  int          fs_count = 0;
  int          ur_total = 0;
  logic [7:0]  lo_hold = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source: present a pixel each cycle, log every slot the DUT takes.
  always @(negedge clk) begin
    bit v;
    #1;
    case (mode)
      1:       v = ((slot_cnt - slot_base) != 2);
      2:       v = ($urandom_range(0, 3) != 0);
      default: v = 1'b1;
    endcase
    pixel_in_valid = v;
    pixel_in       = v ? next_pix : 16'($urandom);
    #1;
    if (!reset && pixel_in_ready) begin
      slot_cnt++;
      if (v) begin
        exp_q.push_back('{hi: next_pix[15:8], lo: next_pix[7:0], ur: 1'b0});
        next_pix = next_pix + 16'h4444;
      end else begin
        exp_q.push_back('{hi: 8'h00, lo: 8'h00, ur: 1'b1});
      end
    end
  end

  // Monitor: frame position model and scoreboard comparison.
  always @(posedge clk) begin
    int c;
    pair_t p;
    #1;
    if (reset) begin
      chk("rst_vsync", vsync, 1);
      chk("rst_href", href, 0);
      chk("rst_pdata", p_data, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_ur", underrun, 0);
      chk("rst_ready", pixel_in_ready, 0);
      fpos = -1;
      exp_q.delete();
      vs_run = 0;
      cont = 1'b0;
    end else begin
      if (underrun) ur_total++;
      if (frame_start) begin
        chk("fs_outside_gap", (fpos < 0), 1);
        if (cont) chk("vsync_len", vs_run, V_SYNC_LINES * LINE_LEN);
        slot_base = slot_cnt;
        fs_count++;
        fpos = 0;
      end
      if (fpos < 0) begin
        chk("gap_vsync", vsync, 1);
        chk("gap_href", href, 0);
        chk("gap_pdata", p_data, 0);
        chk("gap_ur", underrun, 0);
        chk("gap_ready", pixel_in_ready, 0);
        vs_run++;
      end else if (fpos == FRAME_LOW) begin
        chk("end_vsync", vsync, 1);
        chk("end_href", href, 0);
        chk("end_pdata", p_data, 0);
        chk("handshakes", slot_cnt - slot_base, V_ACTIVE * H_ACTIVE);
        chk("sb_leftover", exp_q.size(), 0);
        cont = enable;
        vs_run = 1;
        fpos = -1;
        frames_done++;
      end else begin
        chk("frm_vsync", vsync, 0);
        c = (fpos - VB_CYC) % LINE_LEN;
        if (fpos >= VB_CYC && c < 2 * H_ACTIVE) begin
          chk("act_href", href, 1);
          if (c % 2 == 0) begin
            if (exp_q.size() == 0) begin
              chk("sb_empty", 1, 0);
            end else begin
              p = exp_q.pop_front();
              chk("hi_byte", p_data, p.hi);
              chk("ur_pulse", underrun, p.ur);
              lo_hold = p.lo;
            end
          end else begin
            chk("lo_byte", p_data, lo_hold);
            chk("ur_lo", underrun, 0);
          end
        end else begin
          chk("blank_href", href, 0);
          chk("blank_pdata", p_data, 0);
          chk("blank_ur", underrun, 0);
        end
        fpos++;
      end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    target = frames_done + n;
    for (int i = 0; i < n * 100 + 100 && frames_done < target; i++) @(negedge clk);
    chk("frame_timeout", (frames_done >= target), 1);
  endtask

  task automatic wait_fpos(input int pos);
    for (int i = 0; i < 300 && fpos != pos; i++) @(negedge clk);
    chk("fpos_timeout", fpos, pos);
  endtask

  initial begin
    int ur_base;
    int fs_base;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    // Nominal frames, source always valid.
    wait_frames(3);

    // One starved slot at the third request of a frame.
    mode = 1;
    ur_base = ur_total;
    wait_frames(1);
    chk("underrun_count", ur_total - ur_base, 1);

    // Randomly gapped source.
    mode = 2;
    wait_frames(2);
    mode = 0;

    // Drop enable mid-frame: frame finishes, then no restart.
    wait_fpos(VB_CYC + LINE_LEN + 5);
    enable = 1'b0;
    wait_frames(1);
    fs_base = fs_count;
    repeat (30) @(negedge clk);
    chk("no_restart", fs_count, fs_base);
    chk("idle_vsync", vsync, 1);

    // Reset during an active line, then a full frame again.
    enable = 1'b1;
    wait_fpos(VB_CYC + 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fs_base = fs_count;
    wait_frames(1);
    chk("restart_frames", fs_count - fs_base, 1);
    wait_frames(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_stream_gen.md
CAMERA_STREAM_GEN -- requirements
Module: camera_stream_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_BLANK, default 144: href-low cycles after each active line.
REQ-003 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 SHALL have parameter V_SYNC_LINES, default 3: line periods with vsync high per frame.
REQ-005 SHALL have parameter V_BACK_LINES, default 17: line periods with vsync low and href low before the first active line.
REQ-006 SHALL have port p_clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit: permits frame generation.
REQ-009 SHALL have port pixel_in, input, 16 bits: RGB565 pixel from the source.
REQ-010 SHALL have port pixel_in_valid, input, 1 bit: pixel_in holds valid data.
REQ-011 SHALL have port pixel_in_ready, output, 1 bit: pixel consumed this cycle if valid.
REQ-012 SHALL have port vsync, output, 1 bit: high during vertical sync and idle.
REQ-013 SHALL have port href, output, 1 bit: high while active line bytes are driven.
REQ-014 SHALL have port p_data, output, 8 bits: byte stream, high byte first.
REQ-015 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the vsync falling edge.
REQ-016 SHALL have port underrun, output, 1 bit: one-cycle pulse when a pixel is needed and pixel_in_valid is low.

Function
REQ-017 SHALL register vsync, href, p_data, frame_start and underrun; pixel_in_ready SHALL be combinational from state only, never from pixel_in_valid.
REQ-018 SHALL define LINE_LEN = 2*H_ACTIVE + H_BLANK cycles.
REQ-019 SHALL implement the states IDLE, VSYNC, VBACK, ACTIVE and HBLANK.
REQ-020 IDLE: vsync=1, href=0; enters VSYNC when enable=1.
REQ-021 VSYNC: vsync=1 for V_SYNC_LINES*LINE_LEN cycles, then enters VBACK with frame_start pulsed on the transition cycle.
REQ-022 VBACK: vsync=0, href=0 for V_BACK_LINES*LINE_LEN cycles, then enters ACTIVE.
REQ-023 ACTIVE: href=1 for exactly 2*H_ACTIVE cycles, then enters HBLANK.
REQ-024 HBLANK: href=0 for H_BLANK cycles; if lines remain, enters ACTIVE, else enters VSYNC when enable=1 or IDLE when enable=0.
REQ-025 enable SHALL be sampled only at the IDLE exit and at frame end; deassertion mid-frame completes the current frame.
REQ-026 A byte-phase bit SHALL alternate from 0 in ACTIVE; pixel_in_ready=1 only in the cycle preceding each even byte (last VBACK/HBLANK cycle or odd ACTIVE cycle, excluding the final ACTIVE cycle).
REQ-027 On a handshake (ready and valid), p_data SHALL carry pixel_in[15:8] the next cycle and pixel_in[7:0] the cycle after: 1-cycle latency to the high byte.
REQ-028 Ready with valid low SHALL emit 8'h00 for both bytes of that pixel and pulse underrun aligned with the high byte; timing SHALL be unaffected.
REQ-029 p_data SHALL be 8'h00 whenever href=0.
REQ-030 Line and column counters SHALL be sized with $clog2 of their maximum, SHALL wrap to 0 at each terminal count, and SHALL be cleared by reset.

Reset
REQ-031 Reset SHALL force state IDLE, vsync=1, href=0, p_data=0, frame_start=0, underrun=0, pixel_in_ready=0, and clear all counters and the byte phase.
REQ-032 Reset asserted mid-frame SHALL abort the frame at once; no partial line SHALL be resumed.

Structure
REQ-033 The state enum and default timing constants SHALL live in a shared package camera_pkg.
REQ-034 The block SHALL be a single module with no sub-module.

Verification
REQ-035 Params H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_SYNC_LINES=1, V_BACK_LINES=1, source always valid with pixels 16'h1234, 16'h5678, ... -> vsync high 10 cycles, low 40 cycles, href pulses of 8 cycles x3, p_data 12,34,56,78,...
REQ-036 Same params, pixel_in_valid low at the third ready -> bytes 00,00 in that slot, one underrun pulse, href and vsync timing unchanged.
REQ-037 enable dropped in the middle of line 2 -> frame completes, vsync returns high, state IDLE, no further frame_start.
REQ-038 Reset asserted during ACTIVE -> next cycle vsync=1, href=0, p_data=0; re-enable produces a full frame from VSYNC.
REQ-039 Loopback into the byte-pair receiver -> 12 pixels per frame recovered equal to the source sequence, frame-done seen on each vsync rise.
REQ-040 Count pixel_in_ready handshakes per frame = V_ACTIVE*H_ACTIVE = 12; ready never high in VSYNC or IDLE.
